// File: rtl/axis_lat_pkg.sv
// Shared types and helpers for the AXI-Stream latency monitor.
// Head flit layout, stage-1 bundle, framing states and arithmetic helpers.
package axis_lat_pkg;

    localparam int AXL_TDATA_W = 64;
    localparam int AXL_HALF_W  = AXL_TDATA_W / 2;
    localparam int AXL_TID_W   = 2;
    localparam int AXL_SUM_W   = 48;

    typedef logic [AXL_HALF_W-1:0] half_t;

    typedef struct packed {
        half_t ts;
        half_t seq;
    } head_flit_t;

    typedef struct packed {
        logic                 valid;
        logic [AXL_TID_W-1:0] tid;
        half_t                seq;
        half_t                lat;
        logic                 dest_bad;
        logic                 tid_bad;
    } stage_t;

    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } frame_state_t;

    // Modular subtract: timestamp wrap yields the true elapsed cycles.
    function automatic half_t lat_sub(input half_t now, input half_t ts);
        return now - ts;
    endfunction

    function automatic logic [AXL_SUM_W-1:0] sat_add(
        input logic [AXL_SUM_W-1:0] acc,
        input half_t                val
    );
        logic [AXL_SUM_W:0] s;
        s = {1'b0, acc} + {{(AXL_SUM_W + 1 - AXL_HALF_W){1'b0}}, val};
        return s[AXL_SUM_W] ? '1 : s[AXL_SUM_W-1:0];
    endfunction

endpackage

// File: rtl/axis_latency_monitor_if.sv
// AXI-Stream sink-side bundle for the latency monitor.
// master drives the stream, slave consumes it and returns tready.
interface axis_latency_monitor_if
    import axis_lat_pkg::*;
#(
    parameter int TDATA_WIDTH = AXL_TDATA_W,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = AXL_TID_W
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (
        output tvalid, tdata, tlast, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tid, tdest,
        output tready
    );
endinterface

// File: rtl/axis_lat_stats_bank.sv
// Per-source packet counters and expected-sequence tracking.
// Consumes the stage-1 bundle and raises o_seq_err for the error flag.
module axis_lat_stats_bank
    import axis_lat_pkg::*;
#(
    parameter int NUM_ROUTERS = 4,
    parameter int COUNT_WIDTH = 32
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  stage_t                 i_s1,
    output logic [COUNT_WIDTH-1:0] o_recv [NUM_ROUTERS],
    output logic [COUNT_WIDTH-1:0] o_total,
    output logic [COUNT_WIDTH-1:0] o_seq_errors,
    output logic                   o_seq_err
);
    logic [COUNT_WIDTH-1:0] r_recv [NUM_ROUTERS];
    half_t                  r_exp_seq [NUM_ROUTERS];
    logic [COUNT_WIDTH-1:0] r_total;
    logic [COUNT_WIDTH-1:0] r_seq_errors;
    half_t                  w_exp;
    logic                   w_upd;

    assign w_upd = i_s1.valid & ~i_s1.tid_bad;

    // Read in the update cycle itself: a same-tid packet one cycle
    // behind sees the freshly written entry with no extra bypass.
    always_comb begin
        w_exp = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (i_s1.tid == AXL_TID_W'(i)) begin
                w_exp = r_exp_seq[i];
            end
        end
    end

    assign o_seq_err = w_upd & (i_s1.seq != w_exp);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                r_recv[i]    <= '0;
                r_exp_seq[i] <= '0;
            end
            r_total      <= '0;
            r_seq_errors <= '0;
        end else if (w_upd) begin
            // Match or resync, the next expected value is seq+1.
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                if (i_s1.tid == AXL_TID_W'(i)) begin
                    r_recv[i]    <= r_recv[i] + 1'b1;
                    r_exp_seq[i] <= i_s1.seq + 1'b1;
                end
            end
            r_total <= r_total + 1'b1;
            if (o_seq_err) begin
                r_seq_errors <= r_seq_errors + 1'b1;
            end
        end
    end

    assign o_recv       = r_recv;
    assign o_total      = r_total;
    assign o_seq_errors = r_seq_errors;

endmodule

// File: rtl/axis_latency_monitor.sv
// AXI-Stream sink measuring per-packet latency and sequence order.
// Optional latency histogram enabled by AXIS_LAT_MONITOR_HIST_EN.
module axis_latency_monitor
    import axis_lat_pkg::*;
#(
    parameter int TDATA_WIDTH = AXL_TDATA_W,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = AXL_TID_W,
    parameter int TDEST       = 0,
    parameter int NUM_ROUTERS = 4,
    parameter int COUNT_WIDTH = 32,
`ifdef AXIS_LAT_MONITOR_HIST_EN
    parameter int HIST_BINS   = 16,
    parameter int HIST_SHIFT  = 2,
`endif
    parameter int SUM_WIDTH   = AXL_SUM_W
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [TDATA_WIDTH/2-1:0] ticks,
    axis_latency_monitor_if.slave    axis_in,
    output logic [COUNT_WIDTH-1:0]   recv_packets [NUM_ROUTERS],
    output logic [COUNT_WIDTH-1:0]   total_recv_packets,
    output logic [TDATA_WIDTH/2-1:0] lat_min,
    output logic [TDATA_WIDTH/2-1:0] lat_max,
    output logic [SUM_WIDTH-1:0]     lat_sum,
    output logic [COUNT_WIDTH-1:0]   seq_errors,
    output logic                     error
`ifdef AXIS_LAT_MONITOR_HIST_EN
    ,
    output logic [COUNT_WIDTH-1:0]   lat_hist [HIST_BINS]
`endif
);
    logic                   r_tready;
    frame_state_t           r_state;
    frame_state_t           w_state_nxt;
    logic                   w_hs;
    logic                   w_head;
    head_flit_t             w_flit;
    stage_t                 r_s1;
    logic                   w_seq_err;
    logic                   w_upd;
    half_t                  r_lat_min;
    half_t                  r_lat_max;
    logic [SUM_WIDTH-1:0]   r_lat_sum;
    logic                   r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= 1'b1;
        end
    end

    assign axis_in.tready = r_tready;
    assign w_hs           = axis_in.tvalid & r_tready;
    assign w_flit         = head_flit_t'(axis_in.tdata);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= HEAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head      = 1'b0;
        unique case (r_state)
            HEAD: begin
                if (w_hs) begin
                    w_head = 1'b1;
                    if (!axis_in.tlast) begin
                        w_state_nxt = BODY;
                    end
                end
            end
            BODY: begin
                if (w_hs && axis_in.tlast) begin
                    w_state_nxt = HEAD;
                end
            end
            default: w_state_nxt = HEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= w_head;
            if (w_head) begin
                r_s1.tid      <= axis_in.tid;
                r_s1.seq      <= w_flit.seq;
                r_s1.lat      <= lat_sub(ticks, w_flit.ts);
                r_s1.dest_bad <= (axis_in.tdest != TDEST_WIDTH'(TDEST));
                r_s1.tid_bad  <= ({{(32 - TID_WIDTH){1'b0}}, axis_in.tid}
                                  >= 32'(NUM_ROUTERS));
            end
        end
    end

    axis_lat_stats_bank #(
        .NUM_ROUTERS (NUM_ROUTERS),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_bank (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .i_s1         (r_s1),
        .o_recv       (recv_packets),
        .o_total      (total_recv_packets),
        .o_seq_errors (seq_errors),
        .o_seq_err    (w_seq_err)
    );

    assign w_upd = r_s1.valid & ~r_s1.tid_bad;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_lat_min <= '1;
            r_lat_max <= '0;
            r_lat_sum <= '0;
            r_error   <= 1'b0;
        end else if (r_s1.valid) begin
            if (r_s1.tid_bad) begin
                r_error <= 1'b1;
            end else begin
                if (r_s1.lat < r_lat_min) begin
                    r_lat_min <= r_s1.lat;
                end
                if (r_s1.lat > r_lat_max) begin
                    r_lat_max <= r_s1.lat;
                end
                r_lat_sum <= sat_add(r_lat_sum, r_s1.lat);
                if (r_s1.dest_bad || w_seq_err) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign lat_min = r_lat_min;
    assign lat_max = r_lat_max;
    assign lat_sum = r_lat_sum;
    assign error   = r_error;

`ifdef AXIS_LAT_MONITOR_HIST_EN
    logic [COUNT_WIDTH-1:0] r_hist [HIST_BINS];
    half_t                  w_lat_sh;
    int                     w_bin;

    // Long latencies pile into the last bin.
    always_comb begin
        w_lat_sh = r_s1.lat >> HIST_SHIFT;
        w_bin    = 0;
        if (w_lat_sh >= half_t'(HIST_BINS - 1)) begin
            w_bin = HIST_BINS - 1;
        end else begin
            w_bin = int'(w_lat_sh);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int b = 0; b < HIST_BINS; b++) begin
                r_hist[b] <= '0;
            end
        end else if (w_upd) begin
            for (int b = 0; b < HIST_BINS; b++) begin
                if (b == w_bin && r_hist[b] != '1) begin
                    r_hist[b] <= r_hist[b] + 1'b1;
                end
            end
        end
    end

    assign lat_hist = r_hist;
`endif

endmodule

// File: tb/tb_axis_latency_monitor.sv
// Directed scoreboard bench for axis_latency_monitor.
// Define AXIS_LAT_MONITOR_HIST_EN to also exercise the histogram port.
module tb_axis_latency_monitor;
    import axis_lat_pkg::*;

    localparam int NR = 4;
    localparam int CW = 32;
    localparam int HW = 32;
    localparam int SW = 48;
`ifdef AXIS_LAT_MONITOR_HIST_EN
    localparam int NB = 16;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          clear = 1'b0;
    logic [HW-1:0] ticks = '0;

    axis_latency_monitor_if #(
        .TDATA_WIDTH (64),
        .TDEST_WIDTH (2),
        .TID_WIDTH   (2)
    ) axis_in ();

    logic [CW-1:0] recv_packets [NR];
    logic [CW-1:0] total_recv_packets;
    logic [HW-1:0] lat_min;
    logic [HW-1:0] lat_max;
    logic [SW-1:0] lat_sum;
    logic [CW-1:0] seq_errors;
    logic          error;
`ifdef AXIS_LAT_MONITOR_HIST_EN
    logic [CW-1:0] lat_hist [NB];
`endif

    always #5 clk = ~clk;

    axis_latency_monitor dut (
        .clk                (clk),
        .rst                (rst),
        .clear              (clear),
        .ticks              (ticks),
        .axis_in            (axis_in),
        .recv_packets       (recv_packets),
        .total_recv_packets (total_recv_packets),
        .lat_min            (lat_min),
        .lat_max            (lat_max),
        .lat_sum            (lat_sum),
        .seq_errors         (seq_errors),
`ifdef AXIS_LAT_MONITOR_HIST_EN
        .lat_hist           (lat_hist),
`endif
        .error              (error)
    );

    typedef struct {
        int            due;
        int            tid;
        logic [CW-1:0] recv;
        logic [CW-1:0] total;
        logic [HW-1:0] mn;
        logic [HW-1:0] mx;
        logic [SW-1:0] sum;
        logic [CW-1:0] serr;
        logic          err;
    } snap_t;

    snap_t sbq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [CW-1:0] m_recv [NR];
    logic [HW-1:0] m_seq  [NR];
    logic [CW-1:0] m_total;
    logic [HW-1:0] m_min;
    logic [HW-1:0] m_max;
    logic [SW-1:0] m_sum;
    logic [CW-1:0] m_serr;
    logic          m_err;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_recv[i] = '0;
            m_seq[i]  = '0;
        end
        m_total = '0;
        m_min   = '1;
        m_max   = '0;
        m_sum   = '0;
        m_serr  = '0;
        m_err   = 1'b0;
    endtask

    task automatic check_due();
        snap_t s;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            s = sbq.pop_front();
            chk("sb_due",   64'(cyc), 64'(s.due));
            chk("sb_recv",  recv_packets[s.tid], s.recv);
            chk("sb_total", total_recv_packets, s.total);
            chk("sb_min",   lat_min, s.mn);
            chk("sb_max",   lat_max, s.mx);
            chk("sb_sum",   lat_sum, s.sum);
            chk("sb_serr",  seq_errors, s.serr);
            chk("sb_err",   error, s.err);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_due();
        @(posedge clk);
        cyc++;
        #1;
        ticks = ticks + 1;
    endtask

    task automatic idle();
        axis_in.tvalid = 1'b0;
        axis_in.tlast  = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (3) cycle();
    endtask

    // Drive one head flit; when track is set, update the model and queue.
    task automatic head(input int t, input logic [HW-1:0] seq,
                        input logic [HW-1:0] ts, input logic [HW-1:0] lat,
                        input logic [1:0] dest, input logic last,
                        input bit track);
        snap_t s;
        axis_in.tvalid = 1'b1;
        axis_in.tdata  = {ts, seq};
        axis_in.tlast  = last;
        axis_in.tid    = 2'(t);
        axis_in.tdest  = dest;
        if (track) begin
            m_recv[t] = m_recv[t] + 1;
            m_total   = m_total + 1;
            if (lat < m_min) m_min = lat;
            if (lat > m_max) m_max = lat;
            m_sum = m_sum + SW'(lat);
            if (seq != m_seq[t]) begin
                m_serr = m_serr + 1;
                m_err  = 1'b1;
            end
            m_seq[t] = seq + 1;
            if (dest != 2'd0) m_err = 1'b1;
            s.due   = cyc + 2;
            s.tid   = t;
            s.recv  = m_recv[t];
            s.total = m_total;
            s.mn    = m_min;
            s.mx    = m_max;
            s.sum   = m_sum;
            s.serr  = m_serr;
            s.err   = m_err;
            sbq.push_back(s);
        end
    endtask

    initial begin
        axis_in.tvalid = 1'b0;
        axis_in.tdata  = '0;
        axis_in.tlast  = 1'b0;
        axis_in.tid    = '0;
        axis_in.tdest  = '0;
        model_reset();

        repeat (3) cycle();
        chk("rst_tready", axis_in.tready, 0);
        chk("rst_total", total_recv_packets, 0);
        chk("rst_min", lat_min, 64'hFFFF_FFFF);
        chk("rst_max", lat_max, 0);
        chk("rst_sum", lat_sum, 0);
        chk("rst_serr", seq_errors, 0);
        chk("rst_err", error, 0);
        rst = 1'b0;
        cycle();
        chk("tready_up", axis_in.tready, 1);

        for (int s = 0; s < 10; s++) begin
            for (int t = 0; t < NR; t++) begin
                head(t, HW'(s), ticks - 5, 5, 2'd0, 1'b1, 1'b1);
                cycle();
            end
        end
        drain();
        for (int t = 0; t < NR; t++) begin
            chk("bulk_recv", recv_packets[t], 10);
        end
        chk("bulk_total", total_recv_packets, 40);
        chk("bulk_min", lat_min, 5);
        chk("bulk_max", lat_max, 5);
        chk("bulk_sum", lat_sum, 200);
        chk("bulk_err", error, 0);
`ifdef AXIS_LAT_MONITOR_HIST_EN
        chk("bulk_hist1", lat_hist[1], 40);
`endif

        head(2, 10, ticks - 6, 6, 2'd0, 1'b1, 1'b1);
        cycle();
        head(2, 11, ticks - 9, 9, 2'd0, 1'b1, 1'b1);
        cycle();
        drain();
        chk("fwd_serr", seq_errors, 0);

        head(0, 12, ticks - 5, 5, 2'd0, 1'b1, 1'b0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        idle();
        model_reset();
        chk("clr_total", total_recv_packets, 0);
        chk("clr_recv0", recv_packets[0], 0);
        chk("clr_min", lat_min, 64'hFFFF_FFFF);
        chk("clr_max", lat_max, 0);
        chk("clr_sum", lat_sum, 0);
        chk("clr_serr", seq_errors, 0);
        chk("clr_err", error, 0);
        chk("clr_tready", axis_in.tready, 1);
`ifdef AXIS_LAT_MONITOR_HIST_EN
        for (int b = 0; b < NB; b++) begin
            chk("clr_hist", lat_hist[b], 0);
        end
`endif
        repeat (2) cycle();
        chk("clr_drop_total", total_recv_packets, 0);
        chk("clr_drop_min", lat_min, 64'hFFFF_FFFF);

        head(1, 0, ticks - 4, 4, 2'd0, 1'b1, 1'b1);
        cycle();
        head(1, 1, ticks - 4, 4, 2'd0, 1'b1, 1'b1);
        cycle();
        head(1, 3, ticks - 4, 4, 2'd0, 1'b1, 1'b1);
        cycle();
        head(1, 4, ticks - 4, 4, 2'd0, 1'b1, 1'b1);
        cycle();
        drain();
        chk("seq_serr", seq_errors, 1);
        chk("seq_err", error, 1);
        chk("seq_recv1", recv_packets[1], 4);
        head(1, 5, ticks - 4, 4, 2'd0, 1'b1, 1'b1);
        cycle();
        drain();
        chk("seq5_serr", seq_errors, 1);
        chk("seq5_recv1", recv_packets[1], 5);

        clear = 1'b1;
        cycle();
        clear = 1'b0;
        model_reset();

        head(0, 0, ticks - 7, 7, 2'd0, 1'b0, 1'b1);
        cycle();
        for (int f = 0; f < 3; f++) begin
            axis_in.tdata = {$urandom(), $urandom()};
            axis_in.tid   = 2'($urandom_range(0, 3));
            axis_in.tlast = (f == 2);
            cycle();
        end
        drain();
        chk("multi_total", total_recv_packets, 1);
        chk("multi_min", lat_min, 7);
        chk("multi_max", lat_max, 7);
        chk("multi_sum", lat_sum, 7);

        clear = 1'b1;
        cycle();
        clear = 1'b0;
        model_reset();

        ticks = 32'h0000_0003;
        head(0, 0, 32'hFFFF_FFFE, 5, 2'd0, 1'b1, 1'b1);
        cycle();
        drain();
        chk("wrap_min", lat_min, 5);
        chk("wrap_max", lat_max, 5);
        chk("wrap_err", error, 0);

        head(2, 0, ticks - 3, 3, 2'd2, 1'b1, 1'b1);
        cycle();
        drain();
        chk("dest_err", error, 1);
        chk("dest_recv2", recv_packets[2], 1);
        chk("dest_serr", seq_errors, 0);

        head(3, 0, ticks - 4, 4, 2'd0, 1'b0, 1'b0);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_reset();
        cycle();
        chk("rrst_total", total_recv_packets, 0);
        head(3, 0, ticks - 4, 4, 2'd0, 1'b1, 1'b1);
        cycle();
        drain();
        chk("rrst_recv3", recv_packets[3], 1);
        chk("rrst_total2", total_recv_packets, 1);
        chk("rrst_min", lat_min, 4);

        chk("sb_empty", 64'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_latency_monitor.md
Name: axis_latency_monitor

Overview:
- Synthesizable AXI-Stream sink that sits directly downstream of each NoC output port, in place of or alongside the traffic checker.
- Consumes packets from the torus and decodes the injection timestamp and per-source sequence number carried in the head flit.
- Tracks per-source packet counts and latency min/max/sum, and flags ordering and routing errors.
- Used for load-sweep latency characterisation, both on hardware and in simulation.

Parameters:
- TDATA_WIDTH, 64: flit width; head flit carries [TDATA_WIDTH-1:TDATA_WIDTH/2] = timestamp and [TDATA_WIDTH/2-1:0] = sequence number.
- TDEST_WIDTH, 2: destination field width.
- TID_WIDTH, 2: source-id field width.
- TDEST, 0: this node's own destination id.
- NUM_ROUTERS, 4: number of sources tracked; must be at most 2^TID_WIDTH.
- COUNT_WIDTH, 32: packet counter width.
- SUM_WIDTH, 48: latency accumulator width.
- HIST_BINS, 16: histogram bins (optional feature only).
- HIST_SHIFT, 2: latency right-shift applied to form the bin index (optional feature only).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- clear, in, 1: synchronous statistics clear.
- ticks, in, TDATA_WIDTH/2: free-running cycle counter, the same counter the generators use.
- axis_in_tvalid, in, 1: AXI-Stream valid.
- axis_in_tready, out, 1: AXI-Stream ready.
- axis_in_tdata, in, TDATA_WIDTH: flit payload.
- axis_in_tlast, in, 1: last flit of packet.
- axis_in_tid, in, TID_WIDTH: source id.
- axis_in_tdest, in, TDEST_WIDTH: destination id.
- recv_packets, out, [NUM_ROUTERS][COUNT_WIDTH]: per-source received packet count.
- total_recv_packets, out, COUNT_WIDTH: sum of recv_packets.
- lat_min, out, TDATA_WIDTH/2: minimum latency seen.
- lat_max, out, TDATA_WIDTH/2: maximum latency seen.
- lat_sum, out, SUM_WIDTH: latency accumulator.
- seq_errors, out, COUNT_WIDTH: count of sequence mismatches.
- error, out, 1: sticky error flag.

Behaviour:
- Reset values: tready=0; all counts, lat_max, lat_sum, seq_errors and error =0; lat_min=all-ones; expected_seq[*]=0; framing FSM=HEAD.
- tready is 1 in every cycle after reset is released. The block never backpressures.
- Framing FSM, HEAD / BODY:
  - HEAD with handshake and tlast=0 -> BODY.
  - BODY with handshake and tlast=1 -> HEAD.
  - A single-flit packet (tlast=1 in HEAD) stays in HEAD.
  - Body flits are ignored for statistics.
- Stage 1 (registered on a head-flit handshake) captures:
  - tid;
  - seq = low half of tdata;
  - lat = ticks - ts, computed modulo 2^(TDATA_WIDTH/2) so timestamp wrap is handled;
  - dest_bad = (tdest != TDEST);
  - tid_bad = (tid >= NUM_ROUTERS).
- Stage 2 (cycle after stage 1) updates the statistics. Updates are visible on the outputs 2 cycles after the head handshake.
- Stage 2 when tid_bad: set error only; no counter or statistic updates.
- Stage 2 otherwise:
  - recv_packets[tid]+1 and total_recv_packets+1, both wrapping;
  - lat_min=min(lat_min,lat); lat_max=max(lat_max,lat);
  - lat_sum+lat, saturating at all-ones;
  - dest_bad sets error.
- Sequence check, only when tid_bad is clear:
  - if seq != expected_seq[tid]: seq_errors+1, set error, and resync expected_seq[tid]=seq+1;
  - else expected_seq[tid]+1.
  - Sequence values wrap modulo 2^(TDATA_WIDTH/2).
- total_recv_packets is a registered running counter, not a combinational sum.
- clear:
  - returns every statistic, expected_seq, error and the framing FSM to their reset values in the next cycle;
  - discards any valid stage-1 and stage-2 entries;
  - has priority over a simultaneous head handshake, which is dropped from the statistics;
  - does not touch tready.
- rst asserted mid-packet: FSM returns to HEAD; the next accepted flit is treated as a head flit.
- Back-to-back single-flit packets at one per cycle are fully supported.
- Two consecutive packets from the same tid update stage 2 in consecutive cycles. expected_seq must be forwarded so that the second packet sees the first packet's update.

Optional Feature:
- Macro: AXIS_LAT_MONITOR_HIST_EN.
- Defined:
  - adds output port lat_hist [HIST_BINS][COUNT_WIDTH];
  - stage 2 increments bin min(lat>>HIST_SHIFT, HIST_BINS-1) for every packet with tid_bad clear;
  - reset and clear zero all bins; counters saturate.
- Undefined: the port and histogram logic are absent. All other behaviour is identical.

Decomposition:
- Package axis_lat_pkg holds:
  - the head-flit field typedef (timestamp and sequence halves);
  - typedef stage_t for the stage-1 register (valid, tid, seq, lat, dest_bad, tid_bad);
  - FSM enum {HEAD, BODY};
  - the latency-subtract and saturating-add helper functions.
- One sub-module: axis_lat_stats_bank. It holds the per-source counters, the expected_seq array and the forwarding logic.

Test Plan:
- Sources 0..3 each send 10 single-flit packets, seq 0..9, ts=ticks-5 -> recv_packets={10,10,10,10}, total=40, lat_min=lat_max=5, lat_sum=200, error=0.
- tid=1 sends seq 0,1,3,4 -> seq_errors=1, error=1, recv_packets[1]=4; a following seq 5 causes no new error.
- 4-flit packet with tlast on flit 4, body flits carrying garbage -> exactly one count; latency taken from the head flit only.
- ts=0xFFFFFFFE with ticks=0x00000003 -> lat=5 (wrap handled).
- tdest=2 delivered to a TDEST=0 monitor -> error=1 and the packet is still counted.
- clear asserted in the same cycle as a head handshake from tid 0 -> all statistics read zero next cycle and lat_min=0xFFFFFFFF. With AXIS_LAT_MONITOR_HIST_EN, all bins also read zero.
